// File: rtl/ball_pkg.sv
// Shared definitions for the ball kinematics block: FSM states, wall-hit bit
// positions, and the dead-zone / saturation arithmetic helpers used per axis.
package ball_pkg;

  // Update sequencer states, one cycle each.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_VEL     = 2'd2,
    ST_POS     = 2'd3
  } state_t;

  // Bit positions inside hit_wall = {y_max, y_min, x_max, x_min}.
  localparam int HIT_W     = 4;
  localparam int HIT_X_MIN = 0;
  localparam int HIT_X_MAX = 1;
  localparam int HIT_Y_MIN = 2;
  localparam int HIT_Y_MAX = 3;

  // True when |a| < dz. Done in int so the most negative sample has a
  // representable magnitude and is never mistaken for a small value.
  function automatic logic in_dead_zone(input int a, input int dz);
    return (a > -dz) && (a < dz);
  endfunction

  // Clamp v into [-lim, +lim].
  function automatic int saturate(input int v, input int lim);
    if (v > lim)
      return lim;
    else if (v < -lim)
      return -lim;
    else
      return v;
  endfunction

endpackage

// File: rtl/ball_kinematics_if.sv
// Sample-in / state-out bundle of the ball kinematics block.
// master: the accelerometer side that drives samples and hold, reads results.
// slave: the kinematics engine itself.
interface ball_kinematics_if #(
  parameter int ACC_W = 9,
  parameter int POS_W = 10,
  parameter int VEL_W = 8
);
  import ball_pkg::*;

  logic signed [ACC_W-1:0] accel_x;
  logic signed [ACC_W-1:0] accel_y;
  logic                    hold;
  logic [POS_W-1:0]        x_out;
  logic [POS_W-1:0]        y_out;
  logic signed [VEL_W-1:0] vx_out;
  logic signed [VEL_W-1:0] vy_out;
  logic                    tick_out;
  logic [HIT_W-1:0]        hit_wall;

  modport master (
    output accel_x, accel_y, hold,
    input  x_out, y_out, vx_out, vy_out, tick_out, hit_wall
  );

  modport slave (
    input  accel_x, accel_y, hold,
    output x_out, y_out, vx_out, vy_out, tick_out, hit_wall
  );

endinterface

// File: rtl/ball_axis.sv
// One axis of the ball: dead-zoned sample capture, saturating velocity,
// sub-pixel position integrate and wall clamp/bounce. Each stage is enabled
// for one cycle by the sequencer; hit pulses last exactly one cycle.
module ball_axis
  import ball_pkg::*;
#(
  parameter int ACC_W    = 9,
  parameter int POS_W    = 10,
  parameter int FRAC     = 4,
  parameter int VEL_W    = 8,
  parameter int VMAX     = 32,
  parameter int MAX      = 639,
  parameter int DEADZONE = 8,
  parameter int BOUNCE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    capture_en,
  input  logic                    vel_en,
  input  logic                    pos_en,
  input  logic signed [ACC_W-1:0] accel,
  output logic [POS_W-1:0]        pos_out,
  output logic signed [VEL_W-1:0] vel_out,
  output logic                    hit_min,
  output logic                    hit_max
);

  localparam int IW  = POS_W + FRAC;      // stored position {int, frac}
  localparam int PW  = POS_W + FRAC + 2;  // signed integrate width, room for both overflows
  localparam int SW  = VEL_W + ACC_W;     // velocity sum width
  localparam logic [IW-1:0] P_MAX        = IW'(MAX) << FRAC;
  localparam logic [IW-1:0] P_RST        = IW'(MAX / 2) << FRAC;
  localparam logic signed [PW-1:0] P_MAX_S = $signed({2'b00, P_MAX});
  localparam bit BOUNCE_EN = (BOUNCE != 0);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [VEL_W-1:0] vel_q;
  logic [IW-1:0]           pos_q;
  logic signed [SW-1:0]    vel_sum;
  logic signed [PW-1:0]    p_next;
  logic signed [VEL_W-1:0] vel_half;

  assign vel_sum  = SW'(vel_q) + SW'(acc_q);
  assign p_next   = $signed({2'b00, pos_q}) + {{(PW-VEL_W){vel_q[VEL_W-1]}}, vel_q};
  assign vel_half = vel_q >>> 1;

  // Sample capture with dead zone; velocity and position update with clamp/bounce.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      vel_q   <= '0;
      pos_q   <= P_RST;
      hit_min <= 1'b0;
      hit_max <= 1'b0;
    end else begin
      hit_min <= 1'b0;
      hit_max <= 1'b0;
      if (capture_en)
        acc_q <= in_dead_zone(int'(accel), DEADZONE) ? '0 : accel;
      if (vel_en)
        vel_q <= VEL_W'(saturate(int'(vel_sum), VMAX));
      if (pos_en) begin
        if (p_next < 0) begin
          pos_q   <= '0;
          hit_min <= 1'b1;
          vel_q   <= BOUNCE_EN ? -vel_half : '0;
        end else if (p_next > P_MAX_S) begin
          pos_q   <= P_MAX;
          hit_max <= 1'b1;
          vel_q   <= BOUNCE_EN ? -vel_half : '0;
        end else begin
          pos_q   <= p_next[IW-1:0];
        end
      end
    end
  end

  assign pos_out = pos_q[IW-1:FRAC];
  assign vel_out = vel_q;

endmodule

// File: rtl/ball_kinematics.sv
// Ball mover: integrates accelerometer samples into velocity then position
// once per internal tick, four cycles from tick to valid outputs.
// Ticks seen with hold set, or while an update is running, are dropped.
module ball_kinematics
  import ball_pkg::*;
#(
  parameter int ACC_W    = 9,
  parameter int POS_W    = 10,
  parameter int FRAC     = 4,
  parameter int VEL_W    = 8,
  parameter int VMAX     = 32,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int DEADZONE = 8,
  parameter int TICK_DIV = 1666667,
  parameter int BOUNCE   = 0,
  parameter int SIMULATE = 0
) (
  input  logic               clk,
  input  logic               reset,
  ball_kinematics_if.slave   bus
);

  localparam int TICKS = (SIMULATE != 0) ? 4 : TICK_DIV;
  localparam int CW    = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [CW-1:0] tick_cnt;
  logic          tick;
  state_t        state, state_nxt;
  logic          capture_en, vel_en, pos_en;
  logic          tick_q;
  logic          hit_x_min, hit_x_max, hit_y_min, hit_y_max;

  assign tick = (tick_cnt == CW'(TICKS - 1));

  // Free-running tick divider; keeps counting regardless of hold.
  always_ff @(posedge clk) begin
    if (reset)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Sequencer next state and per-stage enables.
  always_comb begin
    state_nxt  = state;
    capture_en = 1'b0;
    vel_en     = 1'b0;
    pos_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick && !bus.hold)
          state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        capture_en = 1'b1;
        state_nxt  = ST_VEL;
      end
      ST_VEL: begin
        vel_en    = 1'b1;
        state_nxt = ST_POS;
      end
      ST_POS: begin
        pos_en    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // New-position strobe, aligned with the hit pulses from the axes.
  always_ff @(posedge clk) begin
    if (reset)
      tick_q <= 1'b0;
    else
      tick_q <= pos_en;
  end

  ball_axis #(
    .ACC_W(ACC_W), .POS_W(POS_W), .FRAC(FRAC), .VEL_W(VEL_W), .VMAX(VMAX),
    .MAX(X_MAX), .DEADZONE(DEADZONE), .BOUNCE(BOUNCE)
  ) u_axis_x (
    .clk(clk), .reset(reset),
    .capture_en(capture_en), .vel_en(vel_en), .pos_en(pos_en),
    .accel(bus.accel_x),
    .pos_out(bus.x_out), .vel_out(bus.vx_out),
    .hit_min(hit_x_min), .hit_max(hit_x_max)
  );

  ball_axis #(
    .ACC_W(ACC_W), .POS_W(POS_W), .FRAC(FRAC), .VEL_W(VEL_W), .VMAX(VMAX),
    .MAX(Y_MAX), .DEADZONE(DEADZONE), .BOUNCE(BOUNCE)
  ) u_axis_y (
    .clk(clk), .reset(reset),
    .capture_en(capture_en), .vel_en(vel_en), .pos_en(pos_en),
    .accel(bus.accel_y),
    .pos_out(bus.y_out), .vel_out(bus.vy_out),
    .hit_min(hit_y_min), .hit_max(hit_y_max)
  );

  assign bus.tick_out = tick_q;

  // Pack wall hits into their fixed bit slots.
  always_comb begin
    bus.hit_wall            = '0;
    bus.hit_wall[HIT_X_MIN] = hit_x_min;
    bus.hit_wall[HIT_X_MAX] = hit_x_max;
    bus.hit_wall[HIT_Y_MIN] = hit_y_min;
    bus.hit_wall[HIT_Y_MAX] = hit_y_max;
  end

endmodule

// File: tb/tb_ball_kinematics.sv
// Bench for ball_kinematics: two instances (stop-at-wall and bounce) on a
// small 15x15 field, directed scenarios followed by random samples, all
// compared against a plain-arithmetic model of the motion rules.
module tb_ball_kinematics;

  localparam int MAXP = 15;
  localparam int FR   = 4;
  localparam int VM   = 32;
  localparam int DZ   = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  // model state: [dut][axis] with axis 0 = x, 1 = y; position in 1/16 pixel
  int         mp [2][2];
  int         mv [2][2];
  logic [3:0] mhit [2];

  always #5 clk = ~clk;

  ball_kinematics_if #(.ACC_W(9), .POS_W(10), .VEL_W(8)) bus0 ();
  ball_kinematics_if #(.ACC_W(9), .POS_W(10), .VEL_W(8)) bus1 ();

  ball_kinematics #(
    .X_MAX(MAXP), .Y_MAX(MAXP), .FRAC(FR), .VMAX(VM), .DEADZONE(DZ),
    .BOUNCE(0), .SIMULATE(1)
  ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  ball_kinematics #(
    .X_MAX(MAXP), .Y_MAX(MAXP), .FRAC(FR), .VMAX(VM), .DEADZONE(DZ),
    .BOUNCE(1), .SIMULATE(1)
  ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One axis update from the motion rules, plain integer arithmetic.
  task automatic model_axis(input int a, input int bounce, inout int p, inout int v,
                            output logic hmin, output logic hmax);
    if (a > -DZ && a < DZ) a = 0;
    v = v + a;
    if (v > VM) v = VM;
    if (v < -VM) v = -VM;
    p = p + v;
    hmin = 1'b0;
    hmax = 1'b0;
    if (p < 0) begin
      p = 0; hmin = 1'b1;
    end else if (p > MAXP * 16) begin
      p = MAXP * 16; hmax = 1'b1;
    end
    if (hmin || hmax) v = (bounce != 0) ? -(v >>> 1) : 0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int ax = 0; ax < 2; ax++) begin
        mp[d][ax] = (MAXP / 2) * 16;
        mv[d][ax] = 0;
      end
      mhit[d] = 4'b0;
    end
  endtask

  task automatic check_dut(input string tag, input int d, input int x, input int y,
                           input int vx, input int vy, input int hw);
    chk($sformatf("%s.d%0d.x", tag, d), x, mp[d][0] / 16);
    chk($sformatf("%s.d%0d.y", tag, d), y, mp[d][1] / 16);
    chk($sformatf("%s.d%0d.vx", tag, d), vx, mv[d][0]);
    chk($sformatf("%s.d%0d.vy", tag, d), vy, mv[d][1]);
    chk($sformatf("%s.d%0d.hit", tag, d), hw, int'(mhit[d]));
  endtask

  task automatic check_both(input string tag);
    check_dut(tag, 0, int'(bus0.x_out), int'(bus0.y_out), int'($signed(bus0.vx_out)),
              int'($signed(bus0.vy_out)), int'(bus0.hit_wall));
    check_dut(tag, 1, int'(bus1.x_out), int'(bus1.y_out), int'($signed(bus1.vx_out)),
              int'($signed(bus1.vy_out)), int'(bus1.hit_wall));
  endtask

  // Drive samples, advance the model, wait for the strobe, compare, then
  // confirm strobe and hit pulses drop after one cycle.
  task automatic do_update(input string tag, input int ax0, input int ay0,
                           input int ax1, input int ay1);
    bit   seen;
    logic h0, h1, h2, h3;
    bus0.accel_x = 9'(ax0); bus0.accel_y = 9'(ay0);
    bus1.accel_x = 9'(ax1); bus1.accel_y = 9'(ay1);
    model_axis(ax0, 0, mp[0][0], mv[0][0], h0, h1);
    model_axis(ay0, 0, mp[0][1], mv[0][1], h2, h3);
    mhit[0] = {h3, h2, h1, h0};
    model_axis(ax1, 1, mp[1][0], mv[1][0], h0, h1);
    model_axis(ay1, 1, mp[1][1], mv[1][1], h2, h3);
    mhit[1] = {h3, h2, h1, h0};
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus0.tick_out) seen = 1'b1;
    end
    chk({tag, ".tick_seen"}, int'(seen), 1);
    chk({tag, ".tick1"}, int'(bus1.tick_out), 1);
    check_both(tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".tick_drop"}, int'(bus0.tick_out | bus1.tick_out), 0);
    chk({tag, ".hit_drop"}, int'(bus0.hit_wall | bus1.hit_wall), 0);
    mhit[0] = 4'b0;
    mhit[1] = 4'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    bit   seen;
    int   a0, a1, a2, a3;
    reset = 1'b1;
    bus0.accel_x = '0; bus0.accel_y = '0; bus0.hold = 1'b0;
    bus1.accel_x = '0; bus1.accel_y = '0; bus1.hold = 1'b0;

    // 1. reset values, then abort an update in its VEL cycle
    do_reset();
    check_both("reset");
    chk("reset.x_const", int'(bus0.x_out), 7);
    chk("reset.tick", int'(bus0.tick_out), 0);
    do_update("pre_abort", 16, 16, 16, 16);
    @(posedge clk);  // CAPTURE -> VEL
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check_both("abort");
    chk("abort.tick", int'(bus0.tick_out | bus1.tick_out), 0);
    @(posedge clk);
    @(negedge clk);
    chk("abort.tick2", int'(bus0.tick_out | bus1.tick_out), 0);
    chk("abort.vx_const", int'($signed(bus0.vx_out)), 0);
    reset = 1'b0;
    do_reset();

    // 3. dead-zone samples leave motion untouched
    do_update("dz_pos", 5, 0, 5, 0);
    do_update("dz_neg", -7, 0, -7, 0);
    chk("dz.x_const", int'(bus0.x_out), 7);

    // 2. acceleration and velocity saturation
    do_update("acc1", 16, 0, 16, 0);
    chk("acc1.vx_const", int'($signed(bus0.vx_out)), 16);
    chk("acc1.x_const", int'(bus0.x_out), 8);
    do_update("acc2", 16, 0, 16, 0);
    chk("acc2.x_const", int'(bus0.x_out), 10);
    do_update("acc3", 16, 0, 16, 0);
    chk("acc3.vx_const", int'($signed(bus0.vx_out)), 32);
    chk("acc3.x_const", int'(bus0.x_out), 12);

    // 4/5. run into the x_max wall: stop vs bounce
    do_update("wall1", 16, 0, 16, 0);
    chk("wall1.x_const", int'(bus0.x_out), 14);
    do_update("wall2", 16, 0, 16, 0);
    chk("wall2.x0_const", int'(bus0.x_out), 15);
    chk("wall2.vx0_const", int'($signed(bus0.vx_out)), 0);
    chk("wall2.vx1_const", int'($signed(bus1.vx_out)), -16);
    do_update("wall3", 16, 0, 0, 0);
    chk("wall3.x1_const", int'(bus1.x_out), 14);

    // 6. hold freezes motion while ticks pass; release resumes
    bus0.hold = 1'b1; bus1.hold = 1'b1;
    bus0.accel_x = -9'sd256; bus0.accel_y = 9'sd255;
    bus1.accel_x = -9'sd256; bus1.accel_y = 9'sd255;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus0.tick_out || bus1.tick_out) seen = 1'b1;
    end
    chk("hold.no_tick", int'(seen), 0);
    check_both("hold");
    bus0.hold = 1'b0; bus1.hold = 1'b0;
    do_update("release", -256, 255, -256, 255);
    chk("release.x_const", int'(bus0.x_out), 5);
    chk("release.y_const", int'(bus0.y_out), 9);
    chk("release.vx_const", int'($signed(bus0.vx_out)), -32);

    // random samples, full range including the most negative value
    for (int n = 0; n < 40; n++) begin
      a0 = int'($urandom_range(0, 511)) - 256;
      a1 = int'($urandom_range(0, 511)) - 256;
      a2 = int'($urandom_range(0, 31)) - 16;
      a3 = (n % 5 == 0) ? -256 : int'($urandom_range(0, 511)) - 256;
      do_update($sformatf("rnd%0d", n), a0, a1, a2, a3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
